// File: rtl/config_loader.sv
// Serial configuration-chain loader: pulses config_reset, then shifts words LSB-first, two clk per chain bit.
// Optional readback/CRC verify when CONFIG_LOADER_READBACK_EN is defined.
module config_loader #(
    parameter int WORD_W    = 32,
    parameter int CHAIN_LEN = 1024
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              word_valid,
    output logic              word_ready,
    input  logic [WORD_W-1:0] word_data,
    output logic              busy,
    output logic              done,
    output logic              config_clk,
    output logic              config_reset,
    output logic              config_in,
    input  logic              config_out,
    input  logic              verify,
    output logic              verify_err
);

    localparam int NWORDS = (CHAIN_LEN + WORD_W - 1) / WORD_W;
    localparam int BCNT_W = $clog2(CHAIN_LEN + 1);
    localparam int WCNT_W = $clog2(NWORDS + 1);
    localparam int SCNT_W = $clog2(WORD_W + 1);

    typedef enum logic [2:0] {IDLE, CRST, SHIFT, VERIFY, DONE} state_t;

    state_t              state_q, state_d;
    logic                crst_q;
    logic                phase_q;
    logic [BCNT_W-1:0]   bit_cnt_q;
    logic [WCNT_W-1:0]   words_q;
    logic [SCNT_W-1:0]   sh_cnt_q;
    logic                buf_full_q;
    logic [WORD_W-1:0]   sh_q;
    logic [WORD_W-1:0]   buf_q;
    logic                config_clk_q;
    logic                config_in_q;

    logic shifting, verifying, active, all_sent, phase0;
    logic take_sh, accept, direct, issue, load_issue, next_bit, verify_go;

`ifdef CONFIG_LOADER_READBACK_EN
    assign verify_go = verify;
`else
    assign verify_go = 1'b0;
`endif

    assign shifting   = (state_q == SHIFT);
    assign verifying  = (state_q == VERIFY);
    assign active     = shifting || verifying;
    assign all_sent   = (bit_cnt_q == BCNT_W'(CHAIN_LEN));
    assign phase0     = active && !phase_q && !all_sent;
    assign take_sh    = (sh_cnt_q != '0);
    assign word_ready = shifting && !buf_full_q && (words_q < WCNT_W'(NWORDS));
    assign accept     = word_ready && word_valid;
    // With nothing queued, a word accepted at phase 0 feeds its bit 0 straight onto the chain.
    assign issue      = phase0 && (verifying || take_sh || buf_full_q || accept);
    assign load_issue = issue && shifting;
    assign direct     = load_issue && !take_sh && !buf_full_q;
    assign next_bit   = verifying  ? config_out :
                        take_sh    ? sh_q[0]    :
                        buf_full_q ? buf_q[0]   : word_data[0];

    assign busy         = (state_q == CRST) || active;
    assign done         = (state_q == DONE);
    assign config_reset = (state_q == CRST);
    assign config_clk   = config_clk_q;
    assign config_in    = config_in_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:          if (start) state_d = CRST;
                           else if (verify_go) state_d = VERIFY;
            CRST:          if (crst_q) state_d = SHIFT;
            SHIFT, VERIFY: if (!phase_q && all_sent) state_d = DONE;
            DONE:          state_d = IDLE;
            default:       state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crst_q       <= 1'b0;
            phase_q      <= 1'b0;
            bit_cnt_q    <= '0;
            words_q      <= '0;
            sh_cnt_q     <= '0;
            buf_full_q   <= 1'b0;
            config_clk_q <= 1'b0;
            config_in_q  <= 1'b0;
        end else begin
            crst_q <= (state_q == CRST) ? ~crst_q : 1'b0;
            if (state_q == IDLE) begin
                phase_q    <= 1'b0;
                bit_cnt_q  <= '0;
                words_q    <= '0;
                sh_cnt_q   <= '0;
                buf_full_q <= 1'b0;
            end
            if (issue) begin
                config_in_q  <= next_bit;
                config_clk_q <= 1'b0;
                phase_q      <= 1'b1;
                bit_cnt_q    <= bit_cnt_q + BCNT_W'(1);
            end else if (active && phase_q) begin
                config_clk_q <= 1'b1;
                phase_q      <= 1'b0;
            end else begin
                config_clk_q <= 1'b0;
            end
            if (state_d != SHIFT && state_d != VERIFY)
                config_in_q <= 1'b0;
            if (load_issue)
                sh_cnt_q <= take_sh ? sh_cnt_q - SCNT_W'(1) : SCNT_W'(WORD_W - 1);
            if (accept && !direct)
                buf_full_q <= 1'b1;
            else if (load_issue && !take_sh)
                buf_full_q <= 1'b0;
            if (accept)
                words_q <= words_q + WCNT_W'(1);
        end
    end

    // Word data carries no reset; its occupancy flags above decide validity.
    always_ff @(posedge clk) begin
        if (load_issue)
            sh_q <= take_sh ? (sh_q >> 1) : (buf_full_q ? (buf_q >> 1) : (word_data >> 1));
        if (accept && !direct)
            buf_q <= word_data;
    end

`ifdef CONFIG_LOADER_READBACK_EN
    logic [15:0] crc_q, crc_ref_q;
    logic        verify_err_q, op_verify_q;

    function automatic logic [15:0] crc16_step(input logic [15:0] c, input logic b);
        crc16_step = {c[14:0], 1'b0} ^ ((c[15] ^ b) ? 16'h1021 : 16'h0000);
    endfunction

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            crc_q        <= 16'hFFFF;
            crc_ref_q    <= 16'hFFFF;
            verify_err_q <= 1'b0;
            op_verify_q  <= 1'b0;
        end else begin
            if (state_q == IDLE && state_d != IDLE) begin
                crc_q        <= 16'hFFFF;
                verify_err_q <= 1'b0;
                op_verify_q  <= (state_d == VERIFY);
            end else if (issue) begin
                crc_q <= crc16_step(crc_q, next_bit);
            end
            if (state_q == DONE) begin
                if (op_verify_q) verify_err_q <= (crc_q != crc_ref_q);
                else             crc_ref_q    <= crc_q;
            end
        end
    end

    assign verify_err = verify_err_q;
`else
    logic unused_verify;
    assign unused_verify = verify;
    assign verify_err    = 1'b0;
`endif

endmodule
